// File: rtl/lsu_mem_master.sv
// Load/store unit for the MEM stage. It serves byte, half and word loads and
// stores over a word-only data-memory port. Sub-word stores read the word,
// merge the new lane into it, and write the word back.
//
// Handshake: the requester raises req_i and holds it until done_o. A request
// is sampled only in IDLE (busy_o=0). Requests seen while busy_o=1 are
// dropped and never queued. done_o is a one-cycle pulse, and err_o is
// meaningful only while done_o is high.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  state_o
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_bad;
  logic        req_needs_rd;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Reject a request before touching memory: misaligned word/half or word index out of range.
  always_comb begin
    req_bad = 1'b0;
    if ((op_i == OP_LW || op_i == OP_SW) && addr_i[1:0] != 2'b00) req_bad = 1'b1;
    if ((op_i == OP_LH || op_i == OP_LHU || op_i == OP_SH) && addr_i[0]) req_bad = 1'b1;
    if (addr_i[31:2] >= WORD_LIMIT) req_bad = 1'b1;
    // Every load, and every sub-word store (read-modify-write), needs a read cycle.
    req_needs_rd = (op_i != OP_SW);
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (req_bad)           state_d = DONE;
          else if (req_needs_rd) state_d = RD;
          else                   state_d = WR;
        end
      end
      RD:      state_d = (op_q <= OP_LBU) ? DONE : WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the memory strobes decode straight from state, so reset drops them at once.
  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    err_o       = (state_q == DONE) && err_q;
    mem_read_o  = (state_q == RD);
    mem_write_o = (state_q == WR);
    state_o     = state_q;
  end

  // Lane extraction and extension of the word being read this cycle.
  always_comb begin
    sel_byte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    sel_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (op_q)
      OP_LH:   load_val = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_val = {16'h0000, sel_half};
      OP_LB:   load_val = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_val = {24'h000000, sel_byte};
      default: load_val = mem_rdata_i;
    endcase
  end

  // Write word: SW passes the store data; SB/SH merge into the word captured in RD.
  always_comb begin
    merged = word_q;
    case (op_q)
      OP_SB: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      OP_SH: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  // Request latch at accept, plus capture of the read word and the load result in RD.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_i) begin
        op_q    <= op_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        err_q   <= req_bad;
      end
      if (state_q == RD) begin
        word_q <= mem_rdata_i;
        if (op_q <= OP_LBU) rdata_q <= load_val;
      end
    end
  end

  assign rdata_o       = rdata_q;
  assign mem_address_o = {addr_q[31:2], 2'b00};
  assign mem_wdata_o   = merged;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master. It uses a word-wide data memory, checks directed
// cases and then random traffic. The reference model keeps memory as a byte
// array and computes results from the byte lanes.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, err, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;

  logic [31:0] dmem [0:255];
  logic [7:0]  ref_b [0:1023];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          fails = 0;
  int          wr_total = 0;
  logic [31:0] last_rdata = 32'd0;

  lsu_mem_master #(.MEM_WORDS(256)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .op_i(op), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata),
    .mem_address_o(mem_address), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rdata_i(mem_rdata), .state_o(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge.
  assign mem_rdata = dmem[mem_address[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
      dmem[1] <= 32'h0000000A;
      dmem[3] <= 32'h0000000C;
    end else if (mem_write) begin
      dmem[mem_address[9:2]] <= mem_wdata;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model, byte-addressed.
  function automatic bit model_err(input logic [2:0] o, input logic [31:0] a);
    int size;
    size = (o == 0 || o == 5) ? 4 : (o == 1 || o == 2 || o == 6) ? 2 : 1;
    return ((a % size) != 0) || ((a / 4) >= 256);
  endfunction

  function automatic logic [31:0] model_word(input int wi);
    return {ref_b[wi*4+3], ref_b[wi*4+2], ref_b[wi*4+1], ref_b[wi*4]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] o, input int a);
    logic [15:0] h;
    logic [7:0]  b;
    b = ref_b[a];
    h = {ref_b[a|1], ref_b[a & ~1]};
    case (o)
      3'd0:    return model_word(a / 4);
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0, h};
      3'd3:    return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  task automatic model_store(input logic [2:0] o, input int a, input logic [31:0] d);
    int n;
    n = (o == 5) ? 4 : (o == 6) ? 2 : 1;
    for (int i = 0; i < n; i++) ref_b[a + i] = d[8*i +: 8];
  endtask

  // Driver: one request held until done, then checked against the model.
  task automatic do_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    bit e;
    int exp_rd, exp_wr, exp_lat, lat, rd_cnt, wr_cnt;
    logic [31:0] expv;
    e = model_err(o, a);
    exp_rd  = (!e && o != 5) ? 1 : 0;
    exp_wr  = (!e && o >= 5) ? 1 : 0;
    exp_lat = 2 + exp_rd + exp_wr;  // cycles counted inclusive of the accept cycle
    if (!e && o <= 4) last_rdata = model_load(o, int'(a));
    if (!e && o >= 5) model_store(o, int'(a), d);
    exp_q.push_back(last_rdata);

    op = o; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    lat = 1; rd_cnt = 0; wr_cnt = 0;
    while (!done && lat < 10) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read || mem_write) chk("mem_address", mem_address, a & ~32'd3);
      @(posedge clk); #1;
      lat++;
    end
    expv = exp_q.pop_front();
    chk($sformatf("latency op%0d a%h", o, a), 32'(lat + 1), 32'(exp_lat));
    chk($sformatf("err op%0d a%h", o, a), {31'd0, err}, {31'd0, e});
    chk($sformatf("rdata op%0d a%h", o, a), rdata, expv);
    chk("mem_read_count", 32'(rd_cnt), 32'(exp_rd));
    chk("mem_write_count", 32'(wr_cnt), 32'(exp_wr));
    if (!e) chk($sformatf("mem_word %0d", a[9:2]), dmem[a[9:2]], model_word(int'(a[9:2])));
    // req still held during DONE: it must be ignored, so the unit is idle next cycle.
    @(posedge clk); #1;
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    req = 1'b0;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    int          w_before;
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
    ref_b[4]  = 8'h0A;
    ref_b[12] = 8'h0C;

    // Reset and idle values.
    @(posedge clk); @(posedge clk); #1;
    preload = 1'b0;
    chk("reset_ctrl", {26'd0, busy, done, err, mem_read, mem_write, 1'b0}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_txn(3'd0, 32'h04, 32'h0);                  // LW word1
    chk("lw_word1", rdata, 32'h0000000A);
    do_txn(3'd7, 32'h0D, 32'h123456FF);           // SB lane1 of word3
    chk("sb_word3", dmem[3], 32'h0000FF0C);
    do_txn(3'd3, 32'h0D, 32'h0);                  // LB
    chk("lb_sign", rdata, 32'hFFFFFFFF);
    do_txn(3'd4, 32'h0D, 32'h0);                  // LBU
    chk("lbu_zero", rdata, 32'h000000FF);
    do_txn(3'd6, 32'h0E, 32'h00008001);           // SH upper half
    do_txn(3'd1, 32'h0E, 32'h0);                  // LH
    chk("lh_sign", rdata, 32'hFFFF8001);
    do_txn(3'd0, 32'h06, 32'h0);                  // misaligned LW
    do_txn(3'd6, 32'h05, 32'h0);                  // misaligned SH
    do_txn(3'd0, 32'h400, 32'h0);                 // out of range
    chk("rdata_kept_on_err", rdata, 32'hFFFF8001);
    do_txn(3'd5, 32'h08, 32'hDEADBEEF);           // SW
    chk("sw_word2", dmem[2], 32'hDEADBEEF);

    // Random traffic over a small window so stores and loads collide.
    for (int n = 0; n < 40; n++) begin
      r_op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r_addr = 32'($urandom_range(1024, 8191));
      else                           r_addr = 32'($urandom_range(0, 63));
      do_txn(r_op, r_addr, $urandom);
    end

    // Reset during the read cycle of a read-modify-write.
    op = 3'd6; addr = 32'h0C; wdata = 32'h0000BEEF; req = 1'b1;
    @(posedge clk); #1;
    chk("rmw_in_rd", {31'd0, mem_read}, 32'd1);
    w_before = wr_total;
    reset = 1'b1; req = 1'b0;
    #1;
    chk("reset_async_ctrl", {29'd0, busy, mem_read, mem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("no_write_on_reset", 32'(wr_total), 32'(w_before));
    chk("word3_unchanged", dmem[3], model_word(3));
    last_rdata = 32'd0;
    chk("rdata_after_reset", rdata, last_rdata);
    do_txn(3'd0, 32'h0C, 32'h0);                  // unit works after reset

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
